// File: rtl/f_pc_sequencer_pkg.sv
// Shared encodings for the fetch-stage PC sequencer: FSM states, exception codes, default reset PC.
package f_pc_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } f_state_t;

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/f_pc_sequencer_addr_check.sv
// Combinational fetch-address legality check: misaligned or outside [base, limit) is illegal.
module f_addr_check (
    input  logic [31:0] addr,
    input  logic [31:0] base,
    input  logic [31:0] limit,
    output logic        illegal
);

    assign illegal = (addr[1:0] != 2'b00) || (addr < base) || (addr >= limit);

endmodule

// File: rtl/f_pc_sequencer.sv
// F-stage PC register, imem req/ack sequencing and instruction buffer.
// Optional fetch-address exception checking is enabled by defining FETCH_EXC_EN.
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// FETCH | request to pc_F outstanding, buffer empty
// VALID | buffer holds the instruction at pc_F
module f_pc_sequencer
    import f_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] IM_BASE  = 32'h0000_3000,
    parameter logic [31:0] IM_LIMIT = 32'h0000_7000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] npc_in,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_F,
    output logic [31:0] instr_F,
    output logic        valid_F,
    output logic [4:0]  exc_F
);

    f_state_t    state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] target;
    logic [31:0] pc_next;
    logic        fetch;
    logic        fetch_bad;

`ifdef FETCH_EXC_EN
    logic [4:0] exc_q, exc_d;
    logic       addr_bad;

    f_addr_check u_addr_check (
        .addr    (target),
        .base    (IM_BASE),
        .limit   (IM_LIMIT),
        .illegal (addr_bad)
    );

    assign fetch_bad = addr_bad;
    // The faulting PC keeps its low bits so the handler sees the exact bad address.
    assign pc_next   = npc_in;

    always_comb begin
        exc_d = exc_q;
        if (fetch) begin
            exc_d = fetch_bad ? EXC_ADEL : EXC_NONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_q <= EXC_NONE;
        end else begin
            exc_q <= exc_d;
        end
    end

    assign exc_F = exc_q;
`else
    assign fetch_bad = 1'b0;
    assign pc_next   = word_align(npc_in);
    assign exc_F     = EXC_NONE;
`endif

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        target   = pc_q;
        fetch    = 1'b0;
        imem_req = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
            end
            FETCH: begin
                fetch = 1'b1;
            end
            VALID: begin
                // npc_in is only meaningful once the buffered instruction leaves F.
                if (!stall) begin
                    fetch  = 1'b1;
                    target = npc_in;
                    pc_d   = pc_next;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase

        if (fetch) begin
            if (fetch_bad) begin
                instr_d = 32'h0;
                valid_d = 1'b1;
                state_d = VALID;
            end else begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    state_d = VALID;
                end else begin
                    valid_d = 1'b0;
                    state_d = FETCH;
                end
            end
        end
    end

    assign imem_addr = word_align(target);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_F    = pc_q;
    assign instr_F = instr_q;
    assign valid_F = valid_q;

endmodule

// File: tb/tb_f_pc_sequencer.sv
// Bench for f_pc_sequencer: directed vector table, reset/exception sequences, randomized run vs model.
module tb_f_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] npc_in = 32'h0;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc_F;
    logic [31:0] instr_F;
    logic        valid_F;
    logic [4:0]  exc_F;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] pat = 32'h0;

    f_pc_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .npc_in     (npc_in),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .pc_F       (pc_F),
        .instr_F    (instr_F),
        .valid_F    (valid_F),
        .exc_F      (exc_F)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [31:0] npc;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic s, input logic [31:0] n, input logic a,
                                input logic r, input logic [31:0] ad, input logic [31:0] p,
                                input logic v, input logic [31:0] ins);
        vec_t t;
        t.stall = s; t.npc = n; t.ack = a;
        t.e_req = r; t.e_addr = ad; t.e_pc = p; t.e_valid = v; t.e_instr = ins;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle's inputs; memory data is address-based. Returns at the sampling edge.
    task automatic step(input logic s, input logic [31:0] n, input logic a);
        stall = s;
        npc_in = n;
        #1;
        imem_ack = a;
        imem_rdata = imem_addr ^ pat;
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic r, input logic [31:0] ad,
                           input logic [31:0] p, input logic v, input logic [31:0] ins,
                           input logic [4:0] e);
        chk({tag, ".req"}, {31'h0, imem_req}, {31'h0, r});
        if (r) chk({tag, ".addr"}, imem_addr, ad);
        chk({tag, ".pc"}, pc_F, p);
        chk({tag, ".valid"}, {31'h0, valid_F}, {31'h0, v});
        if (v) chk({tag, ".instr"}, instr_F, ins);
        chk({tag, ".exc"}, {27'h0, exc_F}, {27'h0, e});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        imem_ack = 1'b0;
        stall = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Randomized-run reference: the buffer either holds the instruction at exp_pc or is empty
    // awaiting the memory reply; each request is answered after 0..2 wait cycles.
    task automatic random_run(input int cycles);
        logic [31:0] exp_pc = 32'h3000, exp_instr = 32'h0, npc, tgt, held = 32'h0;
        logic        exp_valid = 1'b0, booted = 1'b0, busy = 1'b0, s, a, e_req;
        int          mwait = 0;
        for (int c = 0; c < cycles; c++) begin
            s = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) != 0) npc = exp_pc + 32'd4;
            else npc = $urandom_range(32'h3000 >> 2, (32'h7000 >> 2) - 1) << 2;
`ifndef FETCH_EXC_EN
            if ($urandom_range(0, 7) == 0) npc = npc | 32'($urandom_range(1, 3));
`endif
            stall = s;
            npc_in = npc;
            #1;
            a = 1'b0;
            if (imem_req) begin
                if (!busy) mwait = $urandom_range(0, 2);
                a = (mwait == 0);
            end
            imem_ack = a;
            imem_rdata = imem_addr ^ pat;
            @(negedge clk);
            e_req = booted && (!exp_valid || !s);
            tgt = exp_valid ? {npc[31:2], 2'b00} : exp_pc;
            chk_out("rnd", e_req, tgt, exp_pc, exp_valid, exp_instr, 5'd0);
            if (busy) chk("rnd.held_addr", imem_addr, held);
            if (!booted) begin
                booted = 1'b1;
            end else if (e_req) begin
                exp_pc = tgt;
                if (a) begin
                    exp_valid = 1'b1;
                    exp_instr = tgt ^ pat;
                    busy = 1'b0;
                end else begin
                    exp_valid = 1'b0;
                    busy = 1'b1;
                    held = tgt;
                    mwait--;
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        tbl[0] = mk(0, 32'h0,    0, 0, 32'h3000, 32'h3000, 0, 32'h0);
        tbl[1] = mk(0, 32'h0,    1, 1, 32'h3000, 32'h3000, 0, 32'h0);
        for (int k = 0; k < 8; k++) begin
            tbl[2 + k] = mk(0, 32'h3004 + 32'(4 * k), 1, 1, 32'h3004 + 32'(4 * k),
                            32'h3000 + 32'(4 * k), 1, 32'h3000 + 32'(4 * k));
        end
        tbl[10] = mk(0, 32'h3024, 0, 1, 32'h3024, 32'h3020, 1, 32'h3020);
        tbl[11] = mk(0, 32'h5550, 0, 1, 32'h3024, 32'h3024, 0, 32'h0);
        tbl[12] = mk(0, 32'h5550, 1, 1, 32'h3024, 32'h3024, 0, 32'h0);
        for (int k = 13; k < 16; k++) tbl[k] = mk(1, 32'h3400, 1, 0, 32'h0, 32'h3024, 1, 32'h3024);
        tbl[16] = mk(0, 32'h3400, 0, 1, 32'h3400, 32'h3024, 1, 32'h3024);
        tbl[17] = mk(0, 32'h0,    0, 1, 32'h3400, 32'h3400, 0, 32'h0);
        tbl[18] = mk(0, 32'h0,    1, 1, 32'h3400, 32'h3400, 0, 32'h0);
        tbl[19] = mk(1, 32'h3404, 0, 0, 32'h0,    32'h3400, 1, 32'h3400);
        tbl[20] = mk(0, 32'h3404, 0, 1, 32'h3404, 32'h3400, 1, 32'h3400);
        tbl[21] = mk(1, 32'h0,    0, 1, 32'h3404, 32'h3404, 0, 32'h0);
        tbl[22] = mk(1, 32'h0,    1, 1, 32'h3404, 32'h3404, 0, 32'h0);
        tbl[23] = mk(1, 32'h3408, 0, 0, 32'h0,    32'h3404, 1, 32'h3404);
        tbl[24] = mk(1, 32'h3408, 0, 0, 32'h0,    32'h3404, 1, 32'h3404);

        do_reset();
        chk("reset.instr", instr_F, 32'h0);
        for (int i = 0; i < 25; i++) begin
            step(tbl[i].stall, tbl[i].npc, tbl[i].ack);
            chk_out($sformatf("tbl[%0d]", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_pc,
                    tbl[i].e_valid, tbl[i].e_instr, 5'd0);
            next_cycle();
        end

        // Reset while a request is unacked, then a stray ack during reset.
        step(0, 32'h3500, 0);
        chk_out("pre_rst", 1, 32'h3500, 32'h3404, 1, 32'h3404, 5'd0);
        next_cycle();
        stall = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk_out("async_rst", 0, 32'h0, 32'h3000, 0, 32'h0, 5'd0);
        chk("async_rst.addr", imem_addr, 32'h3000);
        chk("async_rst.instr", instr_F, 32'h0);
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_0000;
        next_cycle();
        reset = 1'b1;
        step(0, 32'h0, 1);
        chk_out("boot", 0, 32'h0, 32'h3000, 0, 32'h0, 5'd0);
        chk("boot.instr", instr_F, 32'h0);
        next_cycle();
        step(0, 32'h0, 0);
        chk_out("refetch", 1, 32'h3000, 32'h3000, 0, 32'h0, 5'd0);
        chk("refetch.instr", instr_F, 32'h0);
        next_cycle();
        step(0, 32'h0, 1);
        chk_out("refetch2", 1, 32'h3000, 32'h3000, 0, 32'h0, 5'd0);
        next_cycle();
        step(1, 32'h3002, 0);
        chk_out("refetched", 0, 32'h0, 32'h3000, 1, 32'h3000, 5'd0);
        next_cycle();

`ifdef FETCH_EXC_EN
        step(0, 32'h3002, 1);
        chk("exc_unal.req", {31'h0, imem_req}, 32'h0);
        next_cycle();
        step(0, 32'h8000, 1);
        chk_out("exc_unal", 0, 32'h0, 32'h3002, 1, 32'h0, 5'd4);
        next_cycle();
        step(0, 32'h3008, 1);
        chk_out("exc_limit", 1, 32'h3008, 32'h8000, 1, 32'h0, 5'd4);
        next_cycle();
        step(1, 32'h0, 0);
        chk_out("exc_clear", 0, 32'h0, 32'h3008, 1, 32'h3008, 5'd0);
        next_cycle();
`else
        step(0, 32'h3409, 1);
        chk_out("unal", 1, 32'h3408, 32'h3000, 1, 32'h3000, 5'd0);
        next_cycle();
        step(1, 32'h0, 0);
        chk_out("unal.pc", 0, 32'h0, 32'h3408, 1, 32'h3408, 5'd0);
        next_cycle();
`endif

        pat = 32'hA5A5_0000;
        do_reset();
        random_run(600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
